// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and default constants for the hazard control unit and its
// memory port arbiter.
//   flush_state_t     : front-end flush sequencer states
//   DEF_*             : default values for the unit's parameters
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int DEF_NUM_FU       = 3;
    localparam int DEF_MAX_BR       = 4;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int PERF_W           = 32;

    typedef enum logic {
        FLUSH_IDLE   = 1'b0,
        FLUSH_ACTIVE = 1'b1
    } flush_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Single memory port shared by committing stores and the load buffer.
// Stores win by default. A load that has been refused STARVE_LIMIT
// consecutive cycles is forced through on the next cycle.
// Ports:
//   clock, reset      : rising-edge clock, async active-low reset
//   commit_wr_mem     : store request from commit
//   lb_read_req       : load request from the load buffer
//   mem_grant_st      : store owns the port this cycle
//   mem_grant_ld      : load owns the port this cycle
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import hazard_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic commit_wr_mem,
    input  logic lb_read_req,
    output logic mem_grant_st,
    output logic mem_grant_ld
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          force_ld;

    assign force_ld     = (starve_cnt == SW'(STARVE_LIMIT));
    assign mem_grant_st = commit_wr_mem & ~force_ld;
    assign mem_grant_ld = lb_read_req & ~mem_grant_st;

    // Counts consecutive refused load cycles; any gap in the request or a
    // successful load restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!lb_read_req || mem_grant_ld) begin
            starve_cnt <= '0;
        end else if (!force_ld) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
// Central stall / flush / grant generator for the out-of-order front end.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// Flush sequencer states:
//   state        | meaning
//   FLUSH_IDLE   | normal issue, no mispredict recovery in progress
//   FLUSH_ACTIVE | front end held in flush for flush_cnt more cycles
//
// Ports:
//   clock, reset           : rising-edge clock, async active-low reset
//   is_valid_inst          : issue stage holds an instruction
//   is_fu_sel[NUM_FU]      : one-hot target reservation station
//   rs_full[NUM_FU]        : reservation station full flags
//   rob_full               : reorder buffer full
//   is_branch              : issuing instruction is a branch
//   br_resolve             : a branch left its FU
//   ex_take_branch         : mispredict, start recovery
//   commit_wr_mem          : store request
//   lb_read_req            : load request
//   wb_valid/wb_written    : per-channel writeback register status
//   if_enable              : fetch may advance
//   if_is_enable           : fetch/issue register may load
//   if_is_flush            : flush fetch/issue register
//   rob_enable             : allocate ROB entry
//   rs_enable[NUM_FU]      : write selected reservation station
//   exec_stall[NUM_FU]     : hold functional unit
//   wb_enable[NUM_FU]      : writeback register may load
//   mem_grant_st/_ld       : memory port grants
//   br_count               : unresolved branches in flight
//   stall_cycles           : (perf) issue-stalled cycles with valid inst
//   flush_events           : (perf) mispredict count
// ---------------------------------------------------------------------------
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int NUM_FU       = DEF_NUM_FU,
    parameter int MAX_BR       = DEF_MAX_BR,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        is_valid_inst,
    input  logic [NUM_FU-1:0]           is_fu_sel,
    input  logic [NUM_FU-1:0]           rs_full,
    input  logic                        rob_full,
    input  logic                        is_branch,
    input  logic                        br_resolve,
    input  logic                        ex_take_branch,
    input  logic                        commit_wr_mem,
    input  logic                        lb_read_req,
    input  logic [NUM_FU-1:0]           wb_valid,
    input  logic [NUM_FU-1:0]           wb_written,
    output logic                        if_enable,
    output logic                        if_is_enable,
    output logic                        if_is_flush,
    output logic                        rob_enable,
    output logic [NUM_FU-1:0]           rs_enable,
    output logic [NUM_FU-1:0]           exec_stall,
    output logic [NUM_FU-1:0]           wb_enable,
    output logic                        mem_grant_st,
    output logic                        mem_grant_ld,
    output logic [$clog2(MAX_BR+1)-1:0] br_count
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]           stall_cycles,
    output logic [PERF_W-1:0]           flush_events
`endif
);

    localparam int BR_W = $clog2(MAX_BR + 1);
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    flush_state_t    state, state_nxt;
    logic [FL_W-1:0] flush_cnt, flush_cnt_nxt;

    logic is_stall;
    logic flushing;
    logic rs_conflict;
    logic br_at_max;
    logic mem_grant_any;
    logic br_inc;
    logic br_dec;

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_mem_arb (
        .clock         (clock),
        .reset         (reset),
        .commit_wr_mem (commit_wr_mem),
        .lb_read_req   (lb_read_req),
        .mem_grant_st  (mem_grant_st),
        .mem_grant_ld  (mem_grant_ld)
    );

    assign flushing      = (state == FLUSH_ACTIVE);
    assign rs_conflict   = |(is_fu_sel & rs_full);
    assign br_at_max     = (br_count == BR_W'(MAX_BR));
    assign is_stall      = rob_full | rs_conflict | br_at_max | flushing;
    assign mem_grant_any = mem_grant_st | mem_grant_ld;

    assign rob_enable   = ~is_stall & is_valid_inst;
    assign rs_enable    = {NUM_FU{rob_enable}} & is_fu_sel;
    assign wb_enable    = ~wb_valid | wb_written;
    assign exec_stall   = ~wb_enable;
    assign if_enable    = ~(is_stall | mem_grant_any);
    assign if_is_enable = ~is_stall;
    // A memory grant steals the cycle from fetch, so the issue register is
    // flushed rather than left holding a duplicate.
    assign if_is_flush  = flushing | ex_take_branch | (mem_grant_any & ~is_stall);

    // Branch in-flight counter; a resolve with nothing outstanding is noise.
    assign br_inc = is_branch & rob_enable;
    assign br_dec = br_resolve & (br_count != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            br_count <= '0;
        end else if (ex_take_branch) begin
            br_count <= '0;
        end else if (br_inc && !br_dec) begin
            br_count <= br_count + BR_W'(1);
        end else if (br_dec && !br_inc) begin
            br_count <= br_count - BR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FLUSH_IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // flush_cnt holds the FLUSH_ACTIVE cycles remaining including the
    // current one; a new mispredict restarts the window.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            FLUSH_IDLE: begin
                if (ex_take_branch) begin
                    state_nxt     = FLUSH_ACTIVE;
                    flush_cnt_nxt = FL_W'(FLUSH_CYCLES);
                end
            end
            FLUSH_ACTIVE: begin
                if (ex_take_branch) begin
                    flush_cnt_nxt = FL_W'(FLUSH_CYCLES);
                end else if (flush_cnt == FL_W'(1)) begin
                    state_nxt     = FLUSH_IDLE;
                    flush_cnt_nxt = '0;
                end else begin
                    flush_cnt_nxt = flush_cnt - FL_W'(1);
                end
            end
            default: begin
                state_nxt     = FLUSH_IDLE;
                flush_cnt_nxt = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (is_stall && is_valid_inst && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (ex_take_branch && (flush_events != '1)) begin
                flush_events <= flush_events + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

    localparam int NUM_FU       = 3;
    localparam int MAX_BR       = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int STARVE_LIMIT = 8;
    localparam int BR_W         = $clog2(MAX_BR + 1);

    logic              clock;
    logic              reset;
    logic              is_valid_inst;
    logic [NUM_FU-1:0] is_fu_sel;
    logic [NUM_FU-1:0] rs_full;
    logic              rob_full;
    logic              is_branch;
    logic              br_resolve;
    logic              ex_take_branch;
    logic              commit_wr_mem;
    logic              lb_read_req;
    logic [NUM_FU-1:0] wb_valid;
    logic [NUM_FU-1:0] wb_written;
    logic              if_enable;
    logic              if_is_enable;
    logic              if_is_flush;
    logic              rob_enable;
    logic [NUM_FU-1:0] rs_enable;
    logic [NUM_FU-1:0] exec_stall;
    logic [NUM_FU-1:0] wb_enable;
    logic              mem_grant_st;
    logic              mem_grant_ld;
    logic [BR_W-1:0]   br_count;
    logic [31:0]       stall_cycles;
    logic [31:0]       flush_events;

    hazard_control_unit #(
        .NUM_FU       (NUM_FU),
        .MAX_BR       (MAX_BR),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .is_valid_inst  (is_valid_inst),
        .is_fu_sel      (is_fu_sel),
        .rs_full        (rs_full),
        .rob_full       (rob_full),
        .is_branch      (is_branch),
        .br_resolve     (br_resolve),
        .ex_take_branch (ex_take_branch),
        .commit_wr_mem  (commit_wr_mem),
        .lb_read_req    (lb_read_req),
        .wb_valid       (wb_valid),
        .wb_written     (wb_written),
        .if_enable      (if_enable),
        .if_is_enable   (if_is_enable),
        .if_is_flush    (if_is_flush),
        .rob_enable     (rob_enable),
        .rs_enable      (rs_enable),
        .exec_stall     (exec_stall),
        .wb_enable      (wb_enable),
        .mem_grant_st   (mem_grant_st),
        .mem_grant_ld   (mem_grant_ld),
        .br_count       (br_count)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
`endif
    );

`ifndef HAZARD_PERF_CNT_EN
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic              rob_enable;
        logic [NUM_FU-1:0] rs_enable;
        logic [NUM_FU-1:0] exec_stall;
        logic [NUM_FU-1:0] wb_enable;
        logic              if_enable;
        logic              if_is_enable;
        logic              if_is_flush;
        logic              gst;
        logic              gld;
        logic [BR_W-1:0]   br;
        logic [31:0]       stall_cyc;
        logic [31:0]       flush_ev;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: branches outstanding, flush cycles still to
    // come, consecutive refused load cycles, perf totals.
    int          m_br;
    int          m_flush_left;
    int          m_starve;
    logic [31:0] m_stall_cyc;
    logic [31:0] m_flush_ev;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        is_valid_inst  = 1'b0;
        is_fu_sel      = '0;
        rs_full        = '0;
        rob_full       = 1'b0;
        is_branch      = 1'b0;
        br_resolve     = 1'b0;
        ex_take_branch = 1'b0;
        commit_wr_mem  = 1'b0;
        lb_read_req    = 1'b0;
        wb_valid       = '0;
        wb_written     = '0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Push the expected response for the current inputs, then advance one
    // clock; returns 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        logic stall, flushing, force_ld, st, ld;
        int nbr, nfl, nst, inc, dec;
        logic [31:0] nsc, nfe;
        if (!reset) begin
            m_br = 0; m_flush_left = 0; m_starve = 0;
            m_stall_cyc = '0; m_flush_ev = '0;
        end
        flushing = (m_flush_left > 0);
        stall    = rob_full || ((is_fu_sel & rs_full) != '0) || (m_br == MAX_BR) || flushing;
        force_ld = (m_starve == STARVE_LIMIT);
        st       = commit_wr_mem && !force_ld;
        ld       = lb_read_req && !st;
        e.rob_enable   = !stall && is_valid_inst;
        e.rs_enable    = e.rob_enable ? is_fu_sel : '0;
        e.wb_enable    = ~wb_valid | wb_written;
        e.exec_stall   = wb_valid & ~wb_written;
        e.if_enable    = !(stall || st || ld);
        e.if_is_enable = !stall;
        e.if_is_flush  = flushing || ex_take_branch || ((st || ld) && !stall);
        e.gst          = st;
        e.gld          = ld;
        e.br           = BR_W'(m_br);
        e.stall_cyc    = m_stall_cyc;
        e.flush_ev     = m_flush_ev;
        exp_q.push_back(e);

        inc = (is_branch && e.rob_enable) ? 1 : 0;
        dec = (br_resolve && m_br > 0) ? 1 : 0;
        nbr = ex_take_branch ? 0 : m_br + inc - dec;
        nfl = ex_take_branch ? FLUSH_CYCLES : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
        nst = (lb_read_req && !ld) ? ((m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1) : 0;
        nsc = (stall && is_valid_inst && m_stall_cyc != 32'hFFFF_FFFF) ? m_stall_cyc + 1 : m_stall_cyc;
        nfe = (ex_take_branch && m_flush_ev != 32'hFFFF_FFFF) ? m_flush_ev + 1 : m_flush_ev;

        @(posedge clock);
        #1;
        if (reset) begin
            m_br = nbr; m_flush_left = nfl; m_starve = nst;
            m_stall_cyc = nsc; m_flush_ev = nfe;
        end else begin
            m_br = 0; m_flush_left = 0; m_starve = 0;
            m_stall_cyc = '0; m_flush_ev = '0;
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("rob_enable",   32'(rob_enable),   32'(e.rob_enable));
            cmp("rs_enable",    32'(rs_enable),    32'(e.rs_enable));
            cmp("exec_stall",   32'(exec_stall),   32'(e.exec_stall));
            cmp("wb_enable",    32'(wb_enable),    32'(e.wb_enable));
            cmp("if_enable",    32'(if_enable),    32'(e.if_enable));
            cmp("if_is_enable", 32'(if_is_enable), 32'(e.if_is_enable));
            cmp("if_is_flush",  32'(if_is_flush),  32'(e.if_is_flush));
            cmp("mem_grant_st", 32'(mem_grant_st), 32'(e.gst));
            cmp("mem_grant_ld", 32'(mem_grant_ld), 32'(e.gld));
            cmp("grant_excl",   32'(mem_grant_st & mem_grant_ld), 32'd0);
            cmp("br_count",     32'(br_count),     32'(e.br));
`ifdef HAZARD_PERF_CNT_EN
            cmp("stall_cycles", stall_cycles, e.stall_cyc);
            cmp("flush_events", flush_events, e.flush_ev);
`endif
        end
    end

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        idle_inputs();
        m_br = 0; m_flush_left = 0; m_starve = 0;
        m_stall_cyc = '0; m_flush_ev = '0;
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        settle();
        cmp("rst_br_count", 32'(br_count), 32'd0);
        cmp("rst_if_is_enable", 32'(if_is_enable), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Branch limit: four dispatched, fifth instruction held.
        is_valid_inst = 1'b1; is_fu_sel = 3'b001; is_branch = 1'b1;
        repeat (4) tick();
        is_branch = 1'b0;
        settle();
        cmp("brmax_count", 32'(br_count), 32'd4);
        cmp("brmax_rob_enable", 32'(rob_enable), 32'd0);
        tick();
        is_valid_inst = 1'b0; br_resolve = 1'b1;
        tick();
        is_valid_inst = 1'b1; br_resolve = 1'b0;
        settle();
        cmp("resume_count", 32'(br_count), 32'd3);
        cmp("resume_rob_enable", 32'(rob_enable), 32'd1);
        tick();

        // Dispatch and resolve together at count 2.
        is_valid_inst = 1'b0; br_resolve = 1'b1;
        tick();
        is_valid_inst = 1'b1; is_branch = 1'b1; br_resolve = 1'b1;
        tick();
        idle_inputs();
        settle();
        cmp("same_cycle_count", 32'(br_count), 32'd2);
        tick();

        // Mispredict: flush window of FLUSH_CYCLES after the trigger cycle.
        is_valid_inst = 1'b1; is_fu_sel = 3'b010; ex_take_branch = 1'b1;
        settle();
        cmp("mp_flush_c10", 32'(if_is_flush), 32'd1);
        tick();
        ex_take_branch = 1'b0;
        for (int c = 11; c <= 12; c++) begin
            settle();
            cmp("mp_flush_hold", 32'(if_is_flush), 32'd1);
            cmp("mp_rob_enable", 32'(rob_enable), 32'd0);
            cmp("mp_br_count", 32'(br_count), 32'd0);
            tick();
        end
        settle();
        cmp("mp_flush_end", 32'(if_is_flush), 32'd0);
        cmp("mp_rob_resume", 32'(rob_enable), 32'd1);
        tick();

        // Store/load contention on the memory port.
        idle_inputs();
        commit_wr_mem = 1'b1; lb_read_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            cmp("arb_st", 32'(mem_grant_st), (i == 8) ? 32'd0 : 32'd1);
            cmp("arb_ld", 32'(mem_grant_ld), (i == 8) ? 32'd1 : 32'd0);
            cmp("arb_if_enable", 32'(if_enable), 32'd0);
            tick();
        end

        // Writeback stalls.
        idle_inputs();
        wb_valid = 3'b010;
        settle();
        cmp("wb_stall", 32'(exec_stall), 32'h2);
        tick();
        wb_written = 3'b010;
        settle();
        cmp("wb_release", 32'(exec_stall), 32'h0);
        tick();

        // Reset mid-cycle with branches outstanding, then mid-flush.
        idle_inputs();
        is_valid_inst = 1'b1; is_fu_sel = 3'b100; is_branch = 1'b1;
        repeat (2) tick();
        idle_inputs();
        #1 reset = 1'b0;
        settle();
        cmp("rst_br_clear", 32'(br_count), 32'd0);
        tick();
        reset = 1'b1;
        ex_take_branch = 1'b1;
        tick();
        ex_take_branch = 1'b0;
        settle();
        cmp("rst_pre_flush", 32'(if_is_flush), 32'd1);
        #1 reset = 1'b0;
        settle();
        cmp("rst_flush_drop", 32'(if_is_flush), 32'd0);
        cmp("rst_flush_br", 32'(br_count), 32'd0);
        tick();
        reset = 1'b1; is_valid_inst = 1'b1; is_fu_sel = 3'b001;
        settle();
        cmp("post_rst_idle", 32'(if_is_flush), 32'd0);
        cmp("post_rst_rob", 32'(rob_enable), 32'd1);
        tick();

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 63) != 0);
            is_valid_inst  = ($urandom_range(0, 3) != 0);
            is_fu_sel      = '0;
            if (is_valid_inst) is_fu_sel[$urandom_range(0, NUM_FU - 1)] = 1'b1;
            rs_full        = ($urandom_range(0, 3) == 0) ? NUM_FU'($urandom) : '0;
            rob_full       = ($urandom_range(0, 7) == 0);
            is_branch      = ($urandom_range(0, 1) == 1);
            br_resolve     = ($urandom_range(0, 3) == 0);
            ex_take_branch = ($urandom_range(0, 19) == 0);
            commit_wr_mem  = (n >= 300) ? 1'b1 : ($urandom_range(0, 1) == 1);
            lb_read_req    = ($urandom_range(0, 3) != 0);
            wb_valid       = NUM_FU'($urandom);
            wb_written     = NUM_FU'($urandom);
            tick();
        end

        reset = 1'b1;
        idle_inputs();
        tick();
        repeat (2) @(negedge clock);
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter NUM_FU, 3, number of issue channels (one RS, one FU and one writeback register each).
REQ-002 SHALL have parameter MAX_BR, 4, maximum unresolved branches in flight.
REQ-003 SHALL have parameter FLUSH_CYCLES, 2, cycles if_is_flush is held after a mispredict.
REQ-004 SHALL have parameter STARVE_LIMIT, 8, consecutive denied cycles before a load wins the memory port.
REQ-005 SHALL have ports: clock in 1 (rising edge); reset in 1 (asynchronous, active-low).
REQ-006 SHALL have ports: is_valid_inst in 1; is_fu_sel in NUM_FU (one-hot target RS); rs_full in NUM_FU; rob_full in 1; is_branch in 1.
REQ-007 SHALL have ports: br_resolve in 1 (branch leaves the FU unstalled); ex_take_branch in 1 (mispredict).
REQ-008 SHALL have ports: commit_wr_mem in 1 (store request); lb_read_req in 1 (load request); wb_valid in NUM_FU; wb_written in NUM_FU.
REQ-009 SHALL have outputs: if_enable, if_is_enable, if_is_flush, rob_enable, each 1.
REQ-010 SHALL have outputs: rs_enable NUM_FU; exec_stall NUM_FU; wb_enable NUM_FU; mem_grant_st 1; mem_grant_ld 1; br_count $clog2(MAX_BR+1).

Function
REQ-011 SHALL compute is_stall = rob_full | OR(is_fu_sel & rs_full) | (br_count==MAX_BR) | flushing, combinationally.
REQ-012 SHALL drive rob_enable = ~is_stall & is_valid_inst; rs_enable[i] = rob_enable & is_fu_sel[i].
REQ-013 SHALL drive wb_enable[i] = ~wb_valid[i] | wb_written[i]; exec_stall[i] = ~wb_enable[i].
REQ-014 SHALL keep a branch counter: +1 on is_branch & rob_enable, -1 on br_resolve, unchanged when both occur in the same cycle.
REQ-015 SHALL clear br_count to 0 on ex_take_branch, overriding any simultaneous increment or decrement.
REQ-016 SHALL never decrement br_count below 0; br_resolve at 0 is ignored.
REQ-017 SHALL run flush FSM IDLE->FLUSH on ex_take_branch, holding FLUSH for exactly FLUSH_CYCLES cycles, then returning to IDLE.
REQ-018 SHALL restart the FLUSH down-counter at FLUSH_CYCLES when ex_take_branch arrives while in FLUSH.
REQ-019 SHALL assert if_is_flush while in FLUSH, in the ex_take_branch cycle itself, and when a memory grant occurs while ~is_stall.
REQ-020 SHALL arbitrate one memory port: mem_grant_st = commit_wr_mem & ~force_ld; mem_grant_ld = lb_read_req & ~mem_grant_st.
REQ-021 SHALL keep a starve counter that increments each cycle lb_read_req is denied, resets to 0 on a load grant or when lb_read_req is low, and saturates at STARVE_LIMIT.
REQ-022 SHALL set force_ld = (starve counter == STARVE_LIMIT); grants SHALL be mutually exclusive in every cycle.
REQ-023 SHALL drive if_enable = ~(is_stall | mem_grant_st | mem_grant_ld); if_is_enable = ~is_stall.

Reset
REQ-024 SHALL, while reset is low, force br_count=0, FSM=IDLE, flush and starve counters=0 and perf counters=0, so that outputs reflect only combinational inputs.
REQ-025 SHALL drop any in-progress FLUSH immediately on reset assertion; the first post-reset edge SHALL be in IDLE.

Configuration
REQ-026 SHALL, with HAZARD_PERF_CNT_EN defined, add 32-bit outputs stall_cycles (+1 per is_stall & is_valid_inst cycle) and flush_events (+1 per ex_take_branch), both saturating at all-ones.
REQ-027 SHALL, without HAZARD_PERF_CNT_EN, omit these ports and counters entirely; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place the flush FSM state enum and default parameter constants in shared package hazard_pkg.
REQ-029 SHALL implement the memory arbitration and starve counter in sub-module mem_port_arbiter.

Verification
REQ-030 SHALL cover: MAX_BR=4, dispatch 4 branches with no resolves -> br_count=4, rob_enable=0 on a 5th valid inst; one br_resolve -> br_count=3, dispatch resumes.
REQ-031 SHALL cover: is_branch dispatch and br_resolve in the same cycle at br_count=2 -> br_count stays 2.
REQ-032 SHALL cover: ex_take_branch at cycle 10, FLUSH_CYCLES=2 -> if_is_flush high in cycles 10-12, br_count=0, rob_enable=0 in cycles 11-12.
REQ-033 SHALL cover: commit_wr_mem and lb_read_req held high continuously -> store granted 8 cycles, load granted on cycle 9, if_enable=0 throughout.
REQ-034 SHALL cover: wb_valid=3'b010, wb_written=0 -> exec_stall=3'b010; wb_written[1]=1 -> exec_stall=0.
REQ-035 SHALL cover: reset pulled low mid-FLUSH -> if_is_flush=0 and br_count=0 immediately, IDLE after release.
